reg_fifo_gen: RTL

Parametrised register-based synchronous FIFO. It is the next-generation general building block for the DMA datapath queues, replacing the fixed depth/width register FIFO wrappers.
Generalised in depth and width, with a selectable read mode: first-word-fall-through or registered. Adds sticky error flags with software clear and a high-watermark occupancy monitor for buffer sizing.

---
 rtl/reg_fifo_pkg.sv | 13 +
 rtl/reg_fifo_mem.sv | 25 ++
 rtl/reg_fifo_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reg_fifo_pkg.sv
// Shared definitions for the register-based FIFO: read-mode selectors and
// derived width helper.
package reg_fifo_pkg;

    localparam int unsigned FWFT_MODE = 1;
    localparam int unsigned REG_MODE  = 0;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int unsigned calcCw(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module reg_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 84
) (
    input  logic                       clockCore,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wrPtr,
    input  logic [WIDTH-1:0]           dataIn,
    input  logic [$clog2(DEPTH)-1:0]   rdPtr,
    output logic [WIDTH-1:0]           rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clockCore) begin
        if (we) begin
            mem[wrPtr] <= dataIn;
        end
    end

    assign rdData = mem[rdPtr];

endmodule

// File: rtl/reg_fifo_gen.sv
// Parametrised register FIFO with selectable FWFT/registered read, threshold
// flags, sticky over/underrun flags and a high-watermark monitor.
module reg_fifo_gen
    import reg_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 84,
    parameter int unsigned FWFT  = FWFT_MODE,
    parameter int unsigned CW    = calcCw(DEPTH)
) (
    input  logic             clockCore,
    input  logic             resetCore,
    input  logic             push,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             pop,
    output logic [WIDTH-1:0] dataOut,
    output logic             full,
    output logic             empty,
    input  logic [CW-1:0]    almostFullThreshold,
    input  logic [CW-1:0]    almostEmptyThreshold,
    output logic             almostFullFlag,
    output logic             almostEmptyFlag,
    output logic [CW-1:0]    fifoDepth,
    output logic [CW-1:0]    highWater,
    output logic             overrun,
    output logic             underrun,
    input  logic             clearStat
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    nextDepth;
    logic [WIDTH-1:0] memRdData;
    logic             popAcc;
    logic             pushAcc;

    // Status decodes come only from the registered count, never from push/pop.
    assign empty           = (fifoDepth == '0);
    assign full            = (fifoDepth == CW'(DEPTH));
    assign almostFullFlag  = (fifoDepth >= almostFullThreshold);
    assign almostEmptyFlag = (fifoDepth <= almostEmptyThreshold);

    assign popAcc  = pop & ~empty;
    assign pushAcc = push & (~full | popAcc);

    always_comb begin
        nextDepth = fifoDepth;
        if (pushAcc && !popAcc) begin
            nextDepth = fifoDepth + CW'(1);
        end else if (!pushAcc && popAcc) begin
            nextDepth = fifoDepth - CW'(1);
        end
    end

    reg_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) uMem (
        .clockCore (clockCore),
        .we        (pushAcc & ~resetCore),
        .wrPtr     (wrPtr),
        .dataIn    (dataIn),
        .rdPtr     (rdPtr),
        .rdData    (memRdData)
    );

    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoDepth <= '0;
        end else begin
            if (pushAcc) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (popAcc) begin
                rdPtr <= rdPtr + AW'(1);
            end
            fifoDepth <= nextDepth;
        end
    end

    // A coincident error event takes priority over a software clear.
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push && !pushAcc) begin
                overrun <= 1'b1;
            end else if (clearStat) begin
                overrun <= 1'b0;
            end
            if (pop && empty) begin
                underrun <= 1'b1;
            end else if (clearStat) begin
                underrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            highWater <= '0;
        end else if (clearStat || (nextDepth > highWater)) begin
            highWater <= nextDepth;
        end
    end

    if (FWFT == FWFT_MODE) begin : gFwft
        // Masked while empty so the reset and drained states read zero.
        assign dataOut = empty ? '0 : memRdData;
    end else begin : gReg
        always_ff @(posedge clockCore) begin
            if (resetCore) begin
                dataOut <= '0;
            end else if (popAcc) begin
                dataOut <= memRdData;
            end
        end
    end

endmodule
